// File: rtl/ysyx_22040127_div_ctrl.sv
// Issue-side controller for the iterative 64-bit radix-2 divider (RV64M DIV/REM family).
// Define DIV_RESULT_CACHE_EN to add a one-entry cache that reuses the last divider result.
`timescale 1ns/1ps
module ysyx_22040127_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic        in_word,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [63:0] div_x,
  output logic [63:0] div_y,
  output logic        div_s,
  output logic        div_is_div,
  output logic        div_stuck,
  input  logic        div_ready,
  input  logic [1:0]  div_state,
  input  logic [63:0] div_quo,
  input  logic [63:0] div_rem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic        r_rem;
  logic        r_word;
  logic        r_signed;
  logic        r_is_div;
  logic [63:0] r_x;
  logic [63:0] r_y;
  logic [63:0] r_result;

  logic        w_signed;
  logic [63:0] w_x;
  logic [63:0] w_y;
  logic [63:0] w_int_min;
  logic        w_div_zero;
  logic        w_overflow;
  logic        w_div_done;

`ifdef DIV_RESULT_CACHE_EN
  logic        r_c_valid;
  logic        r_c_signed;
  logic        r_c_word;
  logic [63:0] r_c_x;
  logic [63:0] r_c_y;
  logic [63:0] r_c_quo;
  logic [63:0] r_c_rem;
  logic        w_hit;
`endif

  function automatic logic [63:0] fmtResult(input logic is_rem, input logic word,
                                            input logic [63:0] quo, input logic [63:0] rem);
    logic [63:0] sel;
    sel = is_rem ? rem : quo;
    return word ? {{32{sel[31]}}, sel[31:0]} : sel;
  endfunction

  // W forms see only the low word, extended according to the signedness of the op.
  assign w_signed   = ~in_op[0];
  assign w_x        = in_word ? (w_signed ? {{32{in_src1[31]}}, in_src1[31:0]}
                                          : {32'b0, in_src1[31:0]}) : in_src1;
  assign w_y        = in_word ? (w_signed ? {{32{in_src2[31]}}, in_src2[31:0]}
                                          : {32'b0, in_src2[31:0]}) : in_src2;
  assign w_int_min  = in_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign w_div_zero = (w_y == 64'd0);
  assign w_overflow = w_signed & (w_x == w_int_min) & (w_y == {64{1'b1}});
  assign w_div_done = div_ready & (div_state == 2'b00);

`ifdef DIV_RESULT_CACHE_EN
  assign w_hit = r_c_valid & (r_c_signed == w_signed) & (r_c_word == in_word) &
                 (r_c_x == w_x) & (r_c_y == w_y);
`endif

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_RESP);
  assign out_result = r_result;
  assign div_x      = r_x;
  assign div_y      = r_y;
  assign div_s      = r_signed;
  assign div_is_div = r_is_div;
  assign div_stuck  = (r_state == S_RESP) & ~out_ready;

  // Operands only change on accept, so the divider sees them stable until it finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rem    <= 1'b0;
      r_word   <= 1'b0;
      r_signed <= 1'b0;
      r_is_div <= 1'b0;
      r_x      <= 64'd0;
      r_y      <= 64'd0;
      r_result <= 64'd0;
`ifdef DIV_RESULT_CACHE_EN
      r_c_valid  <= 1'b0;
      r_c_signed <= 1'b0;
      r_c_word   <= 1'b0;
      r_c_x      <= 64'd0;
      r_c_y      <= 64'd0;
      r_c_quo    <= 64'd0;
      r_c_rem    <= 64'd0;
`endif
    end else begin
      r_is_div <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            r_rem    <= in_op[1];
            r_word   <= in_word;
            r_signed <= w_signed;
            r_x      <= w_x;
            r_y      <= w_y;
            if (w_div_zero) begin
              r_result <= fmtResult(in_op[1], in_word, {64{1'b1}}, w_x);
              r_state  <= S_RESP;
            end else if (w_overflow) begin
              r_result <= fmtResult(in_op[1], in_word, w_x, 64'd0);
              r_state  <= S_RESP;
`ifdef DIV_RESULT_CACHE_EN
            end else if (w_hit) begin
              r_result <= fmtResult(in_op[1], in_word, r_c_quo, r_c_rem);
              r_state  <= S_RESP;
`endif
            end else begin
              r_is_div <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end
        end
        // div_ready may still be high from the previous op here, so it is ignored.
        S_ISSUE: begin
          r_state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= S_DRAIN;
          end else if (w_div_done) begin
            r_result <= fmtResult(r_rem, r_word, div_quo, div_rem);
            r_state  <= S_RESP;
`ifdef DIV_RESULT_CACHE_EN
            r_c_valid  <= 1'b1;
            r_c_signed <= r_signed;
            r_c_word   <= r_word;
            r_c_x      <= r_x;
            r_c_y      <= r_y;
            r_c_quo    <= div_quo;
            r_c_rem    <= div_rem;
`endif
          end
        end
        S_RESP: begin
          if (flush || out_ready) begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_div_done) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_div_ctrl.sv
// Testbench for ysyx_22040127_div_ctrl with a behavioural 68-cycle radix-2 divider model.
// Vectors adapt their expected latency when DIV_RESULT_CACHE_EN is defined.
`timescale 1ns/1ps
module tb_ysyx_22040127_div_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_word;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [63:0] div_x;
  logic [63:0] div_y;
  logic        div_s;
  logic        div_is_div;
  logic        div_stuck;
  logic        div_ready;
  logic [1:0]  div_state;
  logic [63:0] div_quo;
  logic [63:0] div_rem;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [63:0] expQ[$];

`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 0;
`else
  localparam int HIT_LAT = 68;
`endif
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [63:0] exp;
    logic [63:0] expX;
    logic [63:0] expY;
    logic        expS;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  ysyx_22040127_div_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .div_x(div_x), .div_y(div_y), .div_s(div_s), .div_is_div(div_is_div),
    .div_stuck(div_stuck), .div_ready(div_ready), .div_state(div_state),
    .div_quo(div_quo), .div_rem(div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: result and ready appear 66 edges after the start pulse is seen,
  // computed from div_x/div_y/div_s at that moment.
  logic [6:0] mCnt;
  logic       mBusy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_ready <= 1'b0;
      div_state <= 2'b00;
      div_quo   <= 64'd0;
      div_rem   <= 64'd0;
      mBusy     <= 1'b0;
      mCnt      <= 7'd0;
    end else if (div_is_div) begin
      mBusy     <= 1'b1;
      mCnt      <= 7'd1;
      div_ready <= 1'b0;
      div_state <= 2'b01;
    end else if (mBusy) begin
      if (mCnt == 7'd66) begin
        mBusy     <= 1'b0;
        div_ready <= 1'b1;
        div_state <= 2'b00;
        if (div_s) begin
          div_quo <= $signed(div_x) / $signed(div_y);
          div_rem <= $signed(div_x) % $signed(div_y);
        end else begin
          div_quo <= div_x / div_y;
          div_rem <= div_x % div_y;
        end
      end else begin
        mCnt <= mCnt + 7'd1;
        if (mCnt == 7'd33) div_state <= 2'b10;
      end
    end
  end

  always @(posedge clk) begin
    if (div_is_div) pulses <= pulses + 1;
  end

  initial begin
    #400us;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) checkOutput("wait idle timeout", in_ready, 1'b1);
  endtask

  task automatic applyStimulus(input string name, input vec_t v, input int hold);
    int   cyc;
    int   p0;
    logic stable;
    logic holdOk;
    logic [63:0] expv;
    waitIdle();
    in_op     = v.op;
    in_word   = v.word;
    in_src1   = v.src1;
    in_src2   = v.src2;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    p0 = pulses;
    @(posedge clk); #1;
    in_valid = 1'b0;
    expQ.push_back(v.exp);
    cyc = 0;
    stable = 1'b1;
    while (!out_valid && cyc < 200) begin
      if (div_x !== v.expX || div_y !== v.expY || div_s !== v.expS || div_stuck !== 1'b0)
        stable = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (div_x !== v.expX || div_y !== v.expY || div_s !== v.expS) stable = 1'b0;
    checkOutput({name, " latency"}, cyc, v.lat);
    checkOutput({name, " operands"}, stable, 1'b1);
    checkOutput({name, " start pulses"}, pulses - p0, (v.lat == 68) ? 1 : 0);
    if (hold > 0) begin
      holdOk = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (div_stuck !== 1'b1 || out_valid !== 1'b1 || out_result !== v.exp) holdOk = 1'b0;
        @(posedge clk); #1;
      end
      checkOutput({name, " stuck hold"}, holdOk, 1'b1);
      out_ready = 1'b1;
      #1;
      checkOutput({name, " stuck release"}, div_stuck, 1'b0);
    end
    expv = (expQ.size() > 0) ? expQ.pop_front() : ~v.exp;
    checkOutput({name, " result"}, out_result, expv);
    @(posedge clk); #1;
    checkOutput({name, " handshake"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int cyc;
    logic sawValid;
    int p0;
    vec_t v;

    vecs[0]  = '{2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 64'd100, 64'd7, 1'b0, 68};
    vecs[1]  = '{2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 64'd100, 64'd7, 1'b0, HIT_LAT};
    vecs[2]  = '{2'b10, 1'b0, M7, 64'd2, ALL1, M7, 64'd2, 1'b1, 68};
    vecs[3]  = '{2'b00, 1'b0, M7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, M7, 64'd2, 1'b1, HIT_LAT};
    vecs[4]  = '{2'b00, 1'b0, 64'd5, 64'd0, ALL1, 64'd5, 64'd0, 1'b1, 0};
    vecs[5]  = '{2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 64'd5, 64'd0, 1'b0, 0};
    vecs[6]  = '{2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
                 64'hFFFF_FFFF_8000_0000, ALL1, 1'b1, 0};
    vecs[7]  = '{2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0,
                 64'hFFFF_FFFF_8000_0000, ALL1, 1'b1, 0};
    vecs[8]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, ALL1, 64'h8000_0000_0000_0000,
                 64'h8000_0000_0000_0000, ALL1, 1'b1, 0};
    vecs[9]  = '{2'b00, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
                 64'hFFFF_FFFF_FFFF_FFFD, M7, 64'd2, 1'b1, 68};
    vecs[10] = '{2'b01, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'h5555_5555_0000_0003,
                 64'd5, 64'h10, 64'd3, 1'b0, 68};
    vecs[11] = '{2'b01, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ALL1,
                 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 68};
    vecs[12] = '{2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 64'd100, 64'd7, 1'b1, 68};
    vecs[13] = '{2'b10, 1'b0, 64'd100, 64'd7, 64'd2, 64'd100, 64'd7, 1'b1, HIT_LAT};
    vecs[14] = '{2'b01, 1'b0, ALL1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, ALL1, 64'h10, 1'b0, 68};

    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
    in_src1 = 64'd0; in_src2 = 64'd0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    checkOutput("reset in_ready", in_ready, 1'b1);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset out_result", out_result, 64'd0);
    checkOutput("reset div_x", div_x, 64'd0);
    checkOutput("reset div_y", div_y, 64'd0);
    checkOutput("reset div_s", div_s, 1'b0);
    checkOutput("reset div_is_div", div_is_div, 1'b0);
    checkOutput("reset div_stuck", div_stuck, 1'b0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i], 0);
    end

    $display("[TB] back-pressure sequence");
    v = '{2'b01, 1'b0, 64'd1000, 64'd10, 64'd100, 64'd1000, 64'd10, 1'b0, 68};
    applyStimulus("hold", v, 5);

    $display("[TB] flush during WAIT");
    waitIdle();
    in_op = 2'b01; in_word = 1'b0; in_src1 = 64'd77; in_src2 = 64'd7;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    cyc = 11;
    sawValid = 1'b0;
    while (!in_ready && cyc < 300) begin
      if (out_valid) sawValid = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("drain release cycle", cyc, 68);
    checkOutput("drain no output", sawValid, 1'b0);
    v = '{2'b01, 1'b0, 64'd9, 64'd3, 64'd3, 64'd9, 64'd3, 1'b0, 68};
    applyStimulus("after drain", v, 0);

    $display("[TB] flush in IDLE and RESP");
    p0 = pulses;
    in_op = 2'b00; in_word = 1'b0; in_src1 = 64'd5; in_src2 = 64'd0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("idle flush no accept", {out_valid, in_ready}, 2'b01);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("resp before flush", out_valid, 1'b1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("resp flush dropped", {out_valid, in_ready}, 2'b01);
    checkOutput("flush seq no start", pulses - p0, 0);

    $display("[TB] reset mid-operation");
    in_op = 2'b01; in_src1 = 64'd100; in_src2 = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    checkOutput("midreset state", {in_ready, out_valid}, 2'b10);
    checkOutput("midreset div_x", div_x, 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("midreset no output", sawValid, 1'b0);
    v = '{2'b01, 1'b0, 64'd50, 64'd5, 64'd10, 64'd50, 64'd5, 1'b0, 68};
    applyStimulus("after reset", v, 0);

    checkOutput("scoreboard empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
